// File: rtl/sha1_arbiter.sv
// rtl/sha1_arbiter.sv - two-requester round-robin front end for a shared SHA-1 core
// One job at a time: latch the winner's block, strobe the core, wait with a timeout, pulse ACK.

module sha1_arbiter #(
  parameter int TIMEOUT = 200
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           REQ0,
  input  logic           REQ1,
  input  logic [0:511]   DIN0,
  input  logic [0:511]   DIN1,
  output logic           ACK0,
  output logic           ACK1,
  output logic [1:0]     GNT,
  output logic [159:0]   DOUT,
  output logic           ERR,
  output logic           CORE_START,
  output logic [0:511]   CORE_IN,
  input  logic           CORE_DONE,
  input  logic [159:0]   CORE_OUT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t         state, state_nxt;
  logic [7:0]     cnt, cnt_nxt;
  logic           last, last_nxt;
  logic           hold_v, hold_v_nxt;
  logic           hold_idx, hold_idx_nxt;
  logic [1:0]     gnt_nxt;
  logic           ack0_nxt, ack1_nxt;
  logic           start_nxt;
  logic           err_nxt;
  logic [159:0]   dout_nxt;
  logic [0:511]   core_in_nxt;

  logic           req0_m, req1_m, any_req, winner, time_up;

  // The requester served last is blind for exactly one IDLE cycle after its ACK.
  assign req0_m  = REQ0 && !(hold_v && !hold_idx);
  assign req1_m  = REQ1 && !(hold_v &&  hold_idx);
  assign any_req = req0_m || req1_m;
  assign winner  = (req0_m && req1_m) ? ~last : req1_m;
  assign time_up = (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (any_req) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_WAIT;
      S_WAIT:    if (CORE_DONE || time_up) state_nxt = S_DELIVER;
      S_DELIVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values of every registered output and bookkeeping register.
  always_comb begin
    gnt_nxt      = GNT;
    ack0_nxt     = 1'b0;
    ack1_nxt     = 1'b0;
    start_nxt    = 1'b0;
    err_nxt      = ERR;
    dout_nxt     = DOUT;
    core_in_nxt  = CORE_IN;
    cnt_nxt      = cnt;
    last_nxt     = last;
    hold_v_nxt   = hold_v;
    hold_idx_nxt = hold_idx;
    case (state)
      S_IDLE: begin
        hold_v_nxt = 1'b0;
        if (any_req) begin
          gnt_nxt     = winner ? 2'b10 : 2'b01;
          core_in_nxt = winner ? DIN1 : DIN0;
        end
      end
      S_LAUNCH: begin
        start_nxt = 1'b1;
        cnt_nxt   = 8'd0;
      end
      S_WAIT: begin
        // A completion on the final counted cycle still counts as a normal finish.
        if (CORE_DONE) begin
          dout_nxt = CORE_OUT;
          err_nxt  = 1'b0;
          ack0_nxt = GNT[0];
          ack1_nxt = GNT[1];
        end else if (time_up) begin
          dout_nxt = '0;
          err_nxt  = 1'b1;
          ack0_nxt = GNT[0];
          ack1_nxt = GNT[1];
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_DELIVER: begin
        gnt_nxt      = 2'b00;
        last_nxt     = GNT[1];
        hold_v_nxt   = 1'b1;
        hold_idx_nxt = GNT[1];
      end
      default: begin
        gnt_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      GNT        <= 2'b00;
      ACK0       <= 1'b0;
      ACK1       <= 1'b0;
      CORE_START <= 1'b0;
      CORE_IN    <= '0;
      DOUT       <= '0;
      ERR        <= 1'b0;
      cnt        <= 8'd0;
      last       <= 1'b1;
      hold_v     <= 1'b0;
      hold_idx   <= 1'b0;
    end else begin
      GNT        <= gnt_nxt;
      ACK0       <= ack0_nxt;
      ACK1       <= ack1_nxt;
      CORE_START <= start_nxt;
      CORE_IN    <= core_in_nxt;
      DOUT       <= dout_nxt;
      ERR        <= err_nxt;
      cnt        <= cnt_nxt;
      last       <= last_nxt;
      hold_v     <= hold_v_nxt;
      hold_idx   <= hold_idx_nxt;
    end
  end

endmodule
